pr_result_collector: RTL and testbench



---
 rtl/pr_pkg.sv | 24 ++
 rtl/pr_sync_fifo.sv | 52 +++++
 rtl/pr_result_collector.sv | 99 +++++++++
 tb/tb_pr_result_collector.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pr_pkg.sv
// Shared definitions for the add/compare pipe and its result collector:
// default widths, pipe latency, entry layout and a small popcount helper.
package pr_pkg;

  localparam int PR_LATENCY = 3;
  localparam int PR_DATA_W  = 2;
  localparam int PR_SEQ_W   = 4;
  localparam int PR_DEPTH   = 4;
  localparam int PR_STAT_W  = 16;

  typedef struct packed {
    logic [PR_DATA_W-1:0] result;
    logic                 compare;
    logic [PR_SEQ_W-1:0]  seq;
  } pr_entry_t;

  function automatic int unsigned pr_popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/pr_sync_fifo.sv
// DEPTH x WIDTH synchronous FIFO; a push while full is accepted only when a
// pop happens in the same cycle, so the head never moves while stalled.
module pr_sync_fifo #(
  parameter int  WIDTH = 7,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/pr_result_collector.sv
// Collects aligned Result/Compare from the non-stallable add/compare pipe into a
// credit-protected FIFO. Optional pop statistics under PR_COLLECT_STATS_EN.
module pr_result_collector
  import pr_pkg::*;
#(
  parameter int  DATA_W  = PR_DATA_W,
  parameter int  LATENCY = PR_LATENCY,
  parameter int  DEPTH   = PR_DEPTH,
  parameter int  SEQ_W   = PR_SEQ_W,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [DATA_W-1:0] pipe_result,
  input  logic              pipe_compare,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_compare,
  output logic [SEQ_W-1:0]  out_seq,
  output logic              overflow,
  output logic [CNT_W-1:0]  occupancy
`ifdef PR_COLLECT_STATS_EN
  ,
  output logic [PR_STAT_W-1:0] stat_ones,
  output logic [PR_STAT_W-1:0] stat_sum
`endif
);

  localparam int ENTRY_W = DATA_W + 1 + SEQ_W;

  logic [LATENCY-1:0] vld_sr;
  logic [SEQ_W-1:0]   seq_cnt;
  logic [ENTRY_W-1:0] wdata;
  logic [ENTRY_W-1:0] head;
  logic [CNT_W-1:0]   count;
  logic               issue_fire;
  logic               arrival;
  logic               pop_fire;
  logic               push;
  logic               fifo_full;
  logic               fifo_empty;

  // Tokens still in the pipe already own a FIFO slot, so they count against credit.
  assign issue_ready = (32'(count) + pr_popcount(32'(vld_sr))) < 32'(DEPTH);
  assign issue_fire  = issue_valid && issue_ready;
  assign arrival     = vld_sr[LATENCY-1];
  assign pop_fire    = out_valid && out_ready;
  assign push        = arrival && (!fifo_full || pop_fire);
  assign wdata       = {pipe_result, pipe_compare, seq_cnt};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_sr   <= '0;
      seq_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      vld_sr <= (vld_sr << 1) | LATENCY'(issue_fire);
      if (push) seq_cnt <= seq_cnt + SEQ_W'(1);
      if (arrival && !push) overflow <= 1'b1;
    end
  end

  pr_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (wdata),
    .pop     (pop_fire),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  assign out_valid   = !fifo_empty;
  assign out_result  = fifo_empty ? '0 : head[ENTRY_W-1 -: DATA_W];
  assign out_compare = !fifo_empty && head[SEQ_W];
  assign out_seq     = fifo_empty ? '0 : head[SEQ_W-1:0];
  assign occupancy   = count;

`ifdef PR_COLLECT_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_ones <= '0;
      stat_sum  <= '0;
    end else if (pop_fire) begin
      stat_ones <= stat_ones + PR_STAT_W'(out_compare);
      stat_sum  <= stat_sum + PR_STAT_W'(out_result);
    end
  end
`endif

endmodule

// File: tb/tb_pr_result_collector.sv
// Self-checking bench for pr_result_collector: randomized stimulus against a
// queue-based reference model of issue credit, pipe latency and FIFO ordering.
module tb_pr_result_collector;
  import pr_pkg::*;

  localparam int DATA_W  = 2;
  localparam int LATENCY = 3;
  localparam int DEPTH   = 4;
  localparam int SEQ_W   = 4;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              issue_valid = 1'b0;
  logic              issue_ready;
  logic [DATA_W-1:0] pipe_result = '0;
  logic              pipe_compare = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_result;
  logic              out_compare;
  logic [SEQ_W-1:0]  out_seq;
  logic              overflow;
  logic [CNT_W-1:0]  occupancy;
`ifdef PR_COLLECT_STATS_EN
  logic [15:0]       stat_ones;
  logic [15:0]       stat_sum;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  pr_result_collector #(
    .DATA_W  (DATA_W),
    .LATENCY (LATENCY),
    .DEPTH   (DEPTH),
    .SEQ_W   (SEQ_W)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .pipe_result  (pipe_result),
    .pipe_compare (pipe_compare),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_compare  (out_compare),
    .out_seq      (out_seq),
    .overflow     (overflow),
    .occupancy    (occupancy)
`ifdef PR_COLLECT_STATS_EN
    ,
    .stat_ones    (stat_ones),
    .stat_sum     (stat_sum)
`endif
  );

  // Reference model: in-flight issues are arrival edge numbers, the FIFO is a queue.
  pr_entry_t exp_q[$];
  int        inflight[$];
  int        cyc = 0;
  int        m_seq = 0;
  bit        m_ovf = 1'b0;
  bit        force_mode = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
      inflight.delete();
      cyc   = 0;
      m_seq = 0;
      m_ovf = 1'b0;
    end else begin
      bit        fire;
      bit        arr;
      pr_entry_t e;
      cyc++;
      fire = issue_valid && (force_mode || (exp_q.size() + inflight.size() < DEPTH));
      arr  = (inflight.size() > 0) && (inflight[0] == cyc);
      if (arr) void'(inflight.pop_front());
      if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
      if (arr) begin
        if (exp_q.size() < DEPTH) begin
          e.result  = pipe_result;
          e.compare = pipe_compare;
          e.seq     = SEQ_W'(m_seq);
          exp_q.push_back(e);
          m_seq = (m_seq + 1) % (1 << SEQ_W);
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (fire) inflight.push_back(cyc + LATENCY);
    end
  end

  task automatic randomize_pipe();
    pipe_result  = DATA_W'($urandom);
    pipe_compare = 1'($urandom);
  endtask

  task automatic do_reset();
    issue_valid = 1'b0;
    out_ready   = 1'b0;
    reset_n     = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      randomize_pipe();
      #1;
      total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL reset_issue_ready cyc%0d got %0b want 1", i, issue_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid cyc%0d got %0b want 0", i, out_valid); end
      total++; if (occupancy !== '0) begin bad++; $display("FAIL reset_occupancy cyc%0d got %0d want 0", i, occupancy); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow cyc%0d got %0b want 0", i, overflow); end
      total++; if ({out_result, out_compare, out_seq} !== '0) begin bad++; $display("FAIL reset_out_data cyc%0d got %0h want 0", i, {out_result, out_compare, out_seq}); end
      @(negedge clock);
    end
  endtask

  task automatic test_latency();
    do_reset();
    for (int j = 0; j <= LATENCY + 2; j++) begin
      issue_valid = (j == 0);
      if (j == LATENCY) begin
        pipe_result  = 2'b11;
        pipe_compare = 1'b1;
      end else begin
        randomize_pipe();
      end
      @(negedge clock);
      #1;
      if (j < LATENCY) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_early_valid j%0d got %0b want 0", j, out_valid); end
      end else begin
        total++; if (occupancy !== CNT_W'(1)) begin bad++; $display("FAIL latency_occupancy j%0d got %0d want 1", j, occupancy); end
        total++; if ({out_result, out_compare, out_seq} !== {2'd3, 1'b1, 4'd0}) begin
          bad++; $display("FAIL latency_entry j%0d got r=%0d c=%0b s=%0d want r=3 c=1 s=0", j, out_result, out_compare, out_seq);
        end
      end
    end
    issue_valid = 1'b0;
  endtask

  task automatic test_credit();
    int acc;
    do_reset();
    acc = 0;
    issue_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      randomize_pipe();
      #1;
      if (issue_ready) acc++;
      @(negedge clock);
    end
    issue_valid = 1'b0;
    #1;
    total++; if (acc != DEPTH) begin bad++; $display("FAIL credit_accepted got %0d want %0d", acc, DEPTH); end
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL credit_ready_full got %0b want 0", issue_ready); end
    total++; if (occupancy !== CNT_W'(DEPTH)) begin bad++; $display("FAIL credit_occupancy got %0d want %0d", occupancy, DEPTH); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL credit_overflow got %0b want 0", overflow); end
    out_ready = 1'b1;
    #1;
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL credit_same_cycle got %0b want 0", issue_ready); end
    @(negedge clock);
    out_ready = 1'b0;
    #1;
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL credit_after_pop got %0b want 1", issue_ready); end
    total++; if (occupancy !== CNT_W'(DEPTH - 1)) begin bad++; $display("FAIL credit_occ_after_pop got %0d want %0d", occupancy, DEPTH - 1); end
  endtask

  task automatic test_streaming();
    int issued;
    int pops;
    do_reset();
    issued = 0;
    pops = 0;
    out_ready = 1'b1;
    for (int j = 0; j < 200 && pops < 20; j++) begin
      issue_valid = (issued < 20);
      randomize_pipe();
      #1;
      total++; if (issue_ready !== (exp_q.size() + inflight.size() < DEPTH)) begin
        bad++; $display("FAIL stream_issue_ready j%0d got %0b want %0b", j, issue_ready, (exp_q.size() + inflight.size() < DEPTH));
      end
      if (issue_valid && issue_ready) issued++;
      total++; if (occupancy > CNT_W'(1)) begin bad++; $display("FAIL stream_occupancy j%0d got %0d want <=1", j, occupancy); end
      if (out_valid) begin
        total++; if (out_seq !== SEQ_W'(pops % 16)) begin bad++; $display("FAIL stream_seq pop%0d got %0d want %0d", pops, out_seq, pops % 16); end
        total++; if (exp_q.size() == 0 || out_result !== exp_q[0].result || out_compare !== exp_q[0].compare) begin
          bad++; $display("FAIL stream_data pop%0d got r=%0d c=%0b", pops, out_result, out_compare);
        end
        pops++;
      end
      @(negedge clock);
    end
    issue_valid = 1'b0;
    out_ready = 1'b0;
    total++; if (pops != 20) begin bad++; $display("FAIL stream_count got %0d want 20", pops); end
  endtask

  task automatic test_overflow();
    do_reset();
    force_mode = 1'b1;
    force dut.issue_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      issue_valid = 1'b1;
      randomize_pipe();
      @(negedge clock);
    end
    issue_valid = 1'b0;
    release dut.issue_ready;
    force_mode = 1'b0;
    repeat (LATENCY + 1) begin randomize_pipe(); @(negedge clock); end
    #1;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got %0b want 1", overflow); end
    total++; if (occupancy !== CNT_W'(DEPTH)) begin bad++; $display("FAIL ovf_occupancy got %0d want %0d", occupancy, DEPTH); end
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL ovf_ready got %0b want 0", issue_ready); end
    out_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      total++; if (out_seq !== SEQ_W'(k) || exp_q.size() == 0 || out_result !== exp_q[0].result) begin
        bad++; $display("FAIL ovf_drain k%0d got seq=%0d r=%0d want seq=%0d", k, out_seq, out_result, k);
      end
      @(negedge clock);
      #1;
    end
    out_ready = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
    issue_valid = 1'b1;
    @(negedge clock);
    issue_valid = 1'b0;
    repeat (LATENCY) begin randomize_pipe(); @(negedge clock); end
    #1;
    total++; if (out_valid !== 1'b1 || out_seq !== SEQ_W'(DEPTH)) begin
      bad++; $display("FAIL ovf_seq_after got v=%0b seq=%0d want v=1 seq=%0d", out_valid, out_seq, DEPTH);
    end
    issue_valid = 1'b1;
    repeat (2) @(negedge clock);
    issue_valid = 1'b0;
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    repeat (LATENCY + 2) begin randomize_pipe(); @(negedge clock); end
    #1;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_pulse_overflow got %0b want 0", overflow); end
    total++; if (out_valid !== 1'b0 || occupancy !== '0) begin bad++; $display("FAIL rst_pulse_empty got v=%0b occ=%0d want 0", out_valid, occupancy); end
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL rst_pulse_ready got %0b want 1", issue_ready); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      issue_valid = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      randomize_pipe();
      #1;
      total++; if (issue_ready !== (exp_q.size() + inflight.size() < DEPTH)) begin
        bad++; $display("FAIL rand_issue_ready i%0d got %0b want %0b", i, issue_ready, (exp_q.size() + inflight.size() < DEPTH));
      end
      total++; if (occupancy !== CNT_W'(exp_q.size())) begin bad++; $display("FAIL rand_occupancy i%0d got %0d want %0d", i, occupancy, exp_q.size()); end
      total++; if (out_valid !== (exp_q.size() != 0)) begin bad++; $display("FAIL rand_valid i%0d got %0b want %0b", i, out_valid, exp_q.size() != 0); end
      total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rand_overflow i%0d got %0b want %0b", i, overflow, m_ovf); end
      if (exp_q.size() != 0) begin
        total++; if ({out_result, out_compare, out_seq} !== exp_q[0]) begin
          bad++; $display("FAIL rand_head i%0d got %0h want %0h", i, {out_result, out_compare, out_seq}, exp_q[0]);
        end
      end else begin
        total++; if ({out_result, out_compare, out_seq} !== '0) begin
          bad++; $display("FAIL rand_empty_data i%0d got %0h want 0", i, {out_result, out_compare, out_seq});
        end
      end
      @(negedge clock);
    end
    issue_valid = 1'b0;
    out_ready = 1'b0;
  endtask

`ifdef PR_COLLECT_STATS_EN
  task automatic test_stats();
    logic [DATA_W-1:0] vals [3];
    logic              cmps [3];
    vals = '{2'd1, 2'd3, 2'd2};
    cmps = '{1'b1, 1'b0, 1'b1};
    do_reset();
    for (int j = 0; j < LATENCY + 4; j++) begin
      issue_valid = (j < 3);
      if (j >= LATENCY && j < LATENCY + 3) begin
        pipe_result  = vals[j - LATENCY];
        pipe_compare = cmps[j - LATENCY];
      end else begin
        randomize_pipe();
      end
      @(negedge clock);
    end
    issue_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clock);
    out_ready = 1'b0;
    #1;
    total++; if (stat_sum !== 16'd6) begin bad++; $display("FAIL stats_sum got %0d want 6", stat_sum); end
    total++; if (stat_ones !== 16'd2) begin bad++; $display("FAIL stats_ones got %0d want 2", stat_ones); end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_credit();
    test_streaming();
    test_overflow();
    test_random();
`ifdef PR_COLLECT_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
